// File: rtl/regfile_writeback_queue.sv
// Register file write-back queue.
// Collects results from the load unit and the ALU over valid/ready handshakes.
// Results go into a small in-order queue that drives the single register file
// write port, at most one write per cycle. Two combinational forwarding ports
// expose results that are still queued or sitting in the write-port register.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   ld_valid/ld_ready/ld_*          load unit producer (fixed priority)
//   alu_valid/alu_ready/alu_*       ALU producer
//   reg_write_en/write_reg_addr/
//   write_data                      registered register file write port
//   fwdN_addr/fwdN_hit/fwdN_data    forwarding lookups, N = 1, 2
//   count/full/empty                queue occupancy (output register excluded)
module regfile_writeback_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        write_reg_addr,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd1_addr,
  output logic                     fwd1_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  input  logic [ADDR_W-1:0]        fwd2_addr,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NPORT = 2;

  // Queue state
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  occ;
  logic [DEPTH-1:0]  entry_valid;
  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];

  // Handshake and queue control
  logic              ld_fire;
  logic              alu_fire;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic              store;
  logic              pop;

  // Forwarding lookup vectors, one slot per port
  logic [ADDR_W-1:0] lk_addr [NPORT];
  logic              lk_hit  [NPORT];
  logic [DATA_W-1:0] lk_data [NPORT];

  assign count = occ;
  assign full  = (occ == CNT_W'(DEPTH));
  assign empty = (occ == '0);

  // Load unit is older in program order, so it wins; ALU ready depends on ld_valid.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign ld_fire   = ld_valid && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;

  assign push_addr = ld_fire ? ld_addr : alu_addr;
  assign push_data = ld_fire ? ld_data : alu_data;

  // R0 writes complete the handshake but are never stored.
  assign store = (ld_fire || alu_fire) && (push_addr != '0);

  // Head drains into the write-port register whenever anything is queued.
  assign pop = (occ != '0);

  // Pointers, occupancy and entry valid bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      entry_valid <= '0;
    end else begin
      if (store) begin
        tail              <= tail + PTR_W'(1);
        entry_valid[tail] <= 1'b1;
      end
      if (pop) begin
        head              <= head + PTR_W'(1);
        entry_valid[head] <= 1'b0;
      end
      occ <= occ + CNT_W'(store) - CNT_W'(pop);
    end
  end

  // Entry payload storage; contents are only meaningful under entry_valid.
  always_ff @(posedge clk) begin
    if (store) begin
      entry_addr[tail] <= push_addr;
      entry_data[tail] <= push_data;
    end
  end

  // Register file write port; address and data hold when nothing is popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_en   <= 1'b0;
      write_reg_addr <= '0;
      write_data     <= '0;
    end else if (pop) begin
      reg_write_en   <= 1'b1;
      write_reg_addr <= entry_addr[head];
      write_data     <= entry_data[head];
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

  assign lk_addr[0] = fwd1_addr;
  assign lk_addr[1] = fwd2_addr;

  // Forwarding: scan oldest to youngest so the youngest match overwrites.
  // The write-port register is older than anything still in the queue.
  always_comb begin
    for (int p = 0; p < int'(NPORT); p++) begin
      lk_hit[p]  = 1'b0;
      lk_data[p] = '0;
      if (lk_addr[p] != '0) begin
        if (reg_write_en && (write_reg_addr == lk_addr[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = write_data;
        end
        // i = 0 is the youngest entry (tail - 1)
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
          if (entry_valid[PTR_W'(tail - PTR_W'(i + 1))] &&
              (entry_addr[PTR_W'(tail - PTR_W'(i + 1))] == lk_addr[p])) begin
            lk_hit[p]  = 1'b1;
            lk_data[p] = entry_data[PTR_W'(tail - PTR_W'(i + 1))];
          end
        end
      end
    end
  end

  assign fwd1_hit  = lk_hit[0];
  assign fwd1_data = lk_data[0];
  assign fwd2_hit  = lk_hit[1];
  assign fwd2_data = lk_data[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed testbench for regfile_writeback_queue (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_regfile_writeback_queue;

  logic        clk;
  logic        reset_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        reg_write_en;
  logic [3:0]  write_reg_addr;
  logic [31:0] write_data;
  logic [3:0]  fwd1_addr;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic [3:0]  fwd2_addr;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks;
  int errors;

  regfile_writeback_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_addr       (alu_addr),
    .alu_data       (alu_data),
    .reg_write_en   (reg_write_en),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .fwd1_addr      (fwd1_addr),
    .fwd1_hit       (fwd1_hit),
    .fwd1_data      (fwd1_data),
    .fwd2_addr      (fwd2_addr),
    .fwd2_hit       (fwd2_hit),
    .fwd2_data      (fwd2_data),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    fwd1_addr = '0;
    fwd2_addr = '0;

    // Reset state
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_we", 32'(reg_write_en), 32'd0);
    check("rst_waddr", 32'(write_reg_addr), 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    check("rst_fwd2_hit", 32'(fwd2_hit), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single write: R3 = 0x55
    ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 32'h55;
    fwd1_addr = 4'd3;
    #1;
    check("single_ld_ready", 32'(ld_ready), 32'd1);
    check("single_alu_ready", 32'(alu_ready), 32'd0);
    check("single_fwd_input_not_searched", 32'(fwd1_hit), 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("single_count1", 32'(count), 32'd1);
    check("single_we_n1", 32'(reg_write_en), 32'd0);
    check("single_fwdq_hit", 32'(fwd1_hit), 32'd1);
    check("single_fwdq_data", fwd1_data, 32'h55);
    tick();
    check("single_we", 32'(reg_write_en), 32'd1);
    check("single_waddr", 32'(write_reg_addr), 32'd3);
    check("single_wdata", write_data, 32'h55);
    check("single_count0", 32'(count), 32'd0);
    check("single_fwdout_hit", 32'(fwd1_hit), 32'd1);
    check("single_fwdout_data", fwd1_data, 32'h55);
    tick();
    check("single_we_off", 32'(reg_write_en), 32'd0);
    check("single_waddr_hold", 32'(write_reg_addr), 32'd3);
    check("single_wdata_hold", write_data, 32'h55);
    check("single_fwd_miss", 32'(fwd1_hit), 32'd0);
    check("single_fwd_miss_data", fwd1_data, 32'd0);

    // Arbitration: load R1 beats ALU R2
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 32'h10;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h20;
    #1;
    check("arb_ld_ready", 32'(ld_ready), 32'd1);
    check("arb_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("arb_alu_ready2", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("arb_w1_we", 32'(reg_write_en), 32'd1);
    check("arb_w1_addr", 32'(write_reg_addr), 32'd1);
    check("arb_w1_data", write_data, 32'h10);
    check("arb_count", 32'(count), 32'd1);
    tick();
    check("arb_w2_we", 32'(reg_write_en), 32'd1);
    check("arb_w2_addr", 32'(write_reg_addr), 32'd2);
    check("arb_w2_data", write_data, 32'h20);
    tick();
    check("arb_we_off", 32'(reg_write_en), 32'd0);

    // Back-to-back loads R1..R5: drain keeps pace, so the queue never fills
    for (int i = 1; i <= 5; i++) begin
      ld_valid = 1'b1; ld_addr = 4'(i); ld_data = 32'h100 + 32'(i);
      #1;
      check("b2b_ld_ready", 32'(ld_ready), 32'd1);
      tick();
      check("b2b_count", 32'(count), 32'd1);
      check("b2b_full", 32'(full), 32'd0);
      if (i >= 2) begin
        check("b2b_we", 32'(reg_write_en), 32'd1);
        check("b2b_waddr", 32'(write_reg_addr), 32'(i - 1));
        check("b2b_wdata", write_data, 32'h100 + 32'(i - 1));
      end
    end
    ld_valid = 1'b0;
    tick();
    check("b2b_last_we", 32'(reg_write_en), 32'd1);
    check("b2b_last_waddr", 32'(write_reg_addr), 32'd5);
    check("b2b_last_wdata", write_data, 32'h105);
    check("b2b_drained", 32'(count), 32'd0);
    tick();
    check("b2b_we_off", 32'(reg_write_en), 32'd0);

    // R0 drop
    alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 32'hFF;
    #1;
    check("r0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("r0_count", 32'(count), 32'd0);
    check("r0_empty", 32'(empty), 32'd1);
    check("r0_we_a", 32'(reg_write_en), 32'd0);
    tick();
    check("r0_we_b", 32'(reg_write_en), 32'd0);

    // Forwarding: R5=0xA now in write register, R5=0xB younger in queue
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'hA;
    tick();
    ld_data = 32'hB;
    tick();
    ld_valid = 1'b0;
    fwd1_addr = 4'd5; fwd2_addr = 4'd6;
    #1;
    check("fwd_out_we", 32'(reg_write_en), 32'd1);
    check("fwd_out_data", write_data, 32'hA);
    check("fwd1_young_hit", 32'(fwd1_hit), 32'd1);
    check("fwd1_young_data", fwd1_data, 32'hB);
    check("fwd2_miss_hit", 32'(fwd2_hit), 32'd0);
    check("fwd2_miss_data", fwd2_data, 32'd0);
    fwd1_addr = 4'd0;
    #1;
    check("fwd1_r0_hit", 32'(fwd1_hit), 32'd0);
    fwd1_addr = 4'd5;
    tick();
    check("fwd_out2_addr", 32'(write_reg_addr), 32'd5);
    check("fwd_out2_data", write_data, 32'hB);
    check("fwd1_outreg_hit", 32'(fwd1_hit), 32'd1);
    check("fwd1_outreg_data", fwd1_data, 32'hB);
    tick();
    check("fwd1_after_hit", 32'(fwd1_hit), 32'd0);

    // Reset mid-operation: R9 in write register, R10 queued
    ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 32'h99;
    tick();
    ld_addr = 4'd10; ld_data = 32'hAA;
    tick();
    ld_valid = 1'b0;
    fwd1_addr = 4'd10;
    #1;
    check("mid_pre_count", 32'(count), 32'd1);
    check("mid_pre_we", 32'(reg_write_en), 32'd1);
    check("mid_pre_fwd", 32'(fwd1_hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_we", 32'(reg_write_en), 32'd0);
    check("mid_waddr", 32'(write_reg_addr), 32'd0);
    check("mid_fwd_hit", 32'(fwd1_hit), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_we_a", 32'(reg_write_en), 32'd0);
    check("post_count", 32'(count), 32'd0);
    tick();
    check("post_we_b", 32'(reg_write_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
